// File: rtl/esm_pkg.sv
// rtl/esm_pkg.sv - slot states, instruction field positions and x0 constant for the ESM dependency tracker
package esm_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE   = 2'd0,
        SLOT_WAIT   = 2'd1,
        SLOT_ISSUED = 2'd2
    } slot_state_e;

    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int REG_X0  = 0;

endpackage

// File: rtl/esm_age_select.sv
// rtl/esm_age_select.sv - age matrix and oldest-ready selector for the ESM dependency tracker
module esm_age_select #(
    parameter  int BS  = 16,
    localparam int BSB = $clog2(BS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ins_valid_i,
    input  logic [BSB-1:0]  ins_index_i,
    input  logic [0:BS-1]   occ_i,
    input  logic            clr_valid_i,
    input  logic [BSB-1:0]  clr_index_i,
    input  logic [0:BS-1]   ready_i,
    output logic            sel_valid_o,
    output logic [BSB-1:0]  sel_index_o
);

    // older_q[i][j] set means entry j was already live when entry i was inserted
    logic [0:BS-1] older_q [BS];
    logic [0:BS-1] older_d [BS];
    logic [0:BS-1] sel_onehot;

    // Next age matrix: a freed slot drops its row and column, a new entry records every live slot as older
    always_comb begin
        for (int i = 0; i < BS; i++) begin
            older_d[i] = older_q[i];
            if (clr_valid_i) begin
                older_d[i][clr_index_i] = 1'b0;
                if (clr_index_i == BSB'(i)) begin
                    older_d[i] = '0;
                end
            end
            if (ins_valid_i && ins_index_i == BSB'(i)) begin
                older_d[i] = occ_i;
            end
        end
    end

    // Age matrix register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BS; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BS; i++) begin
                older_q[i] <= older_d[i];
            end
        end
    end

    // Oldest ready entry: ready with no older ready entry; live entries are totally ordered so this is one-hot
    always_comb begin
        sel_onehot  = '0;
        sel_index_o = '0;
        for (int i = 0; i < BS; i++) begin
            sel_onehot[i] = ready_i[i] && ((older_q[i] & ready_i) == '0);
            if (sel_onehot[i]) begin
                sel_index_o = BSB'(i);
            end
        end
        sel_valid_o = |ready_i;
    end

endmodule

// File: rtl/esm_dep_tracker.sv
// rtl/esm_dep_tracker.sv - dependency-tracking issue buffer; define ESM_WAR_WAW_EN to also track WAR/WAW hazards
module esm_dep_tracker
    import esm_pkg::*;
#(
    parameter  int IW     = 32,
    parameter  int BS     = 16,
    parameter  int REGNUM = 32,
    localparam int BSB    = $clog2(BS),
    localparam int RB     = $clog2(REGNUM)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   in_instr,
    input  logic            in_regwrite,
    input  logic            in_alusrc,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [BSB-1:0]  issue_index,
    output logic [IW-1:0]   issue_instr,
    input  logic            cmp_valid,
    input  logic [BSB-1:0]  cmp_index,
    output logic [0:BS-1]   valid_vec,
    output logic [0:BS-1]   ready_vec,
    output logic [BSB:0]    count
);

    localparam logic [BSB:0]  CNT_FULL = (BSB+1)'(BS);
    localparam logic [RB-1:0] X0       = RB'(REG_X0);

    slot_state_e    state_q [BS];
    slot_state_e    state_d [BS];
    logic [0:BS-1]  dep_q   [BS];
    logic [0:BS-1]  dep_d   [BS];
    logic [RB-1:0]  rd_q    [BS];
    logic [RB-1:0]  rs1_q   [BS];
    logic [RB-1:0]  rs2_q   [BS];
    logic [IW-1:0]  instr_q [BS];
    logic [BSB:0]   count_q, count_d;

    logic [RB-1:0]  in_rd, in_rs1, in_rs2;
    logic [BSB-1:0] alloc_idx;
    logic [BSB-1:0] sel_idx;
    logic           sel_valid;
    logic           ins_fire, iss_fire, cmp_fire;
    logic [0:BS-1]  live_vec;
    logic [0:BS-1]  new_row;

    // Operand fields with non-writing rd and immediate rs2 folded onto x0
    assign in_rd  = in_regwrite ? in_instr[RD_LSB +: RB] : X0;
    assign in_rs1 = in_instr[RS1_LSB +: RB];
    assign in_rs2 = in_alusrc ? X0 : in_instr[RS2_LSB +: RB];

    assign in_ready = (count_q < CNT_FULL);
    assign count    = count_q;
    assign ins_fire = in_valid && in_ready;
    assign iss_fire = sel_valid && issue_ready;
    assign cmp_fire = cmp_valid && (state_q[cmp_index] == SLOT_ISSUED);

    // Lowest-index free slot, taken from registered state so a slot freed this cycle is not reused yet
    always_comb begin
        alloc_idx = '0;
        for (int i = BS - 1; i >= 0; i--) begin
            if (state_q[i] == SLOT_FREE) begin
                alloc_idx = BSB'(i);
            end
        end
    end

    // Occupancy, readiness and the set of entries a new insert must compare against
    always_comb begin
        for (int j = 0; j < BS; j++) begin
            valid_vec[j] = (state_q[j] != SLOT_FREE);
            ready_vec[j] = (state_q[j] == SLOT_WAIT) && (dep_q[j] == '0);
            live_vec[j]  = valid_vec[j] && !(cmp_fire && cmp_index == BSB'(j));
        end
    end

    // Dependency row of the incoming instruction against every live entry
    always_comb begin
        for (int j = 0; j < BS; j++) begin
            new_row[j] = live_vec[j] && (rd_q[j] != X0) &&
                         ((rd_q[j] == in_rs1) || (rd_q[j] == in_rs2));
`ifdef ESM_WAR_WAW_EN
            if (live_vec[j] && (in_rd != X0) &&
                ((in_rd == rd_q[j]) || (in_rd == rs1_q[j]) || (in_rd == rs2_q[j]))) begin
                new_row[j] = 1'b1;
            end
`endif
        end
    end

    // Slot state and dependency matrix next-state: completion, issue and insert touch disjoint slots
    always_comb begin
        for (int i = 0; i < BS; i++) begin
            state_d[i] = state_q[i];
            dep_d[i]   = dep_q[i];
            if (cmp_fire) begin
                dep_d[i][cmp_index] = 1'b0;
                if (cmp_index == BSB'(i)) begin
                    state_d[i] = SLOT_FREE;
                    dep_d[i]   = '0;
                end
            end
            if (iss_fire && sel_idx == BSB'(i)) begin
                state_d[i] = SLOT_ISSUED;
            end
            if (ins_fire && alloc_idx == BSB'(i)) begin
                state_d[i] = SLOT_WAIT;
                dep_d[i]   = new_row;
            end
        end
        count_d = count_q;
        if (ins_fire) count_d = count_d + (BSB+1)'(1);
        if (cmp_fire) count_d = count_d - (BSB+1)'(1);
    end

    // Slot state, dependency matrix and occupancy counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BS; i++) begin
                state_q[i] <= SLOT_FREE;
                dep_q[i]   <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < BS; i++) begin
                state_q[i] <= state_d[i];
                dep_q[i]   <= dep_d[i];
            end
            count_q <= count_d;
        end
    end

    // Payload capture into the allocated slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BS; i++) begin
                rd_q[i]    <= '0;
                rs1_q[i]   <= '0;
                rs2_q[i]   <= '0;
                instr_q[i] <= '0;
            end
        end else if (ins_fire) begin
            rd_q[alloc_idx]    <= in_rd;
            rs1_q[alloc_idx]   <= in_rs1;
            rs2_q[alloc_idx]   <= in_rs2;
            instr_q[alloc_idx] <= in_instr;
        end
    end

    esm_age_select #(
        .BS (BS)
    ) u_age_select (
        .clk         (clk),
        .rst         (rst),
        .ins_valid_i (ins_fire),
        .ins_index_i (alloc_idx),
        .occ_i       (live_vec),
        .clr_valid_i (cmp_fire),
        .clr_index_i (cmp_index),
        .ready_i     (ready_vec),
        .sel_valid_o (sel_valid),
        .sel_index_o (sel_idx)
    );

    assign issue_valid = sel_valid;
    assign issue_index = sel_idx;
    assign issue_instr = sel_valid ? instr_q[sel_idx] : '0;

endmodule

// File: tb/tb_esm_dep_tracker.sv
// tb/tb_esm_dep_tracker.sv - directed self-checking bench for esm_dep_tracker
module tb_esm_dep_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        in_regwrite;
    logic        in_alusrc;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_index;
    logic [31:0] issue_instr;
    logic        cmp_valid;
    logic [3:0]  cmp_index;
    logic [0:15] valid_vec;
    logic [0:15] ready_vec;
    logic [4:0]  count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    esm_dep_tracker dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_regwrite (in_regwrite),
        .in_alusrc   (in_alusrc),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_index (issue_index),
        .issue_instr (issue_instr),
        .cmp_valid   (cmp_valid),
        .cmp_index   (cmp_index),
        .valid_vec   (valid_vec),
        .ready_vec   (ready_vec),
        .count       (count)
    );

    function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
        logic [4:0] a, b, c;
        a = rd[4:0];
        b = rs1[4:0];
        c = rs2[4:0];
        return {7'd0, c, b, 3'd0, a, 7'h33};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insert(input logic [31:0] instr);
        in_valid = 1'b1;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic issue_one(input int idx, input string tag);
        chk({tag, "_ivalid"}, 32'(issue_valid), 32'd1);
        chk({tag, "_iindex"}, 32'(issue_index), 32'(idx));
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
    endtask

    task automatic complete(input int idx);
        cmp_valid = 1'b1;
        cmp_index = idx[3:0];
        tick();
        cmp_valid = 1'b0;
    endtask

    task automatic drain_one(input int idx, input string tag);
        issue_one(idx, tag);
        complete(idx);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_instr    = '0;
        in_regwrite = 1'b1;
        in_alusrc   = 1'b0;
        issue_ready = 1'b0;
        cmp_valid   = 1'b0;
        cmp_index   = '0;
        #2 rst = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_issue_index", 32'(issue_index), 32'd0);
        chk("rst_issue_instr", issue_instr, 32'd0);
        chk("rst_valid_vec", 32'(valid_vec), 32'd0);
        chk("rst_ready_vec", 32'(ready_vec), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        rst = 1'b1;

        // independent insert is offered right after its edge
        insert(mk(3, 1, 2));
        chk("ins0_valid_vec", 32'(valid_vec), 32'h8000);
        chk("ins0_ready_vec", 32'(ready_vec), 32'h8000);
        chk("ins0_issue_valid", 32'(issue_valid), 32'd1);
        chk("ins0_issue_index", 32'(issue_index), 32'd0);
        chk("ins0_issue_instr", issue_instr, mk(3, 1, 2));
        chk("ins0_count", 32'(count), 32'd1);

        // RAW on slot 0
        insert(mk(5, 3, 4));
        chk("raw_valid_vec", 32'(valid_vec), 32'hC000);
        chk("raw_ready_vec", 32'(ready_vec), 32'h8000);
        chk("raw_count", 32'(count), 32'd2);
        complete(1);
        chk("cmp_wait_ignored_count", 32'(count), 32'd2);
        chk("cmp_wait_ignored_valid", 32'(valid_vec), 32'hC000);
        issue_one(0, "raw_iss0");
        chk("raw_after_issue_ready", 32'(ready_vec), 32'd0);
        chk("raw_after_issue_ivalid", 32'(issue_valid), 32'd0);
        complete(0);
        chk("wake_ready_vec", 32'(ready_vec), 32'h4000);
        chk("wake_valid_vec", 32'(valid_vec), 32'h4000);
        chk("wake_count", 32'(count), 32'd1);
        drain_one(1, "raw_drain1");
        chk("raw_empty_count", 32'(count), 32'd0);

        // fill all slots
        for (int k = 0; k < 16; k++) begin
            insert(mk(k + 1, 0, 0));
        end
        chk("full_count", 32'(count), 32'd16);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_valid_vec", 32'(valid_vec), 32'hFFFF);
        chk("full_ready_vec", 32'(ready_vec), 32'hFFFF);
        insert(mk(21, 0, 0));
        chk("full_reject_count", 32'(count), 32'd16);
        issue_one(0, "full_iss0");
        chk("full_next_index", 32'(issue_index), 32'd1);
        in_valid  = 1'b1;
        in_instr  = mk(20, 0, 0);
        cmp_valid = 1'b1;
        cmp_index = 4'd0;
        tick();
        cmp_valid = 1'b0;
        chk("free_count", 32'(count), 32'd15);
        chk("free_in_ready", 32'(in_ready), 32'd1);
        chk("free_valid_vec", 32'(valid_vec), 32'h7FFF);
        tick();
        in_valid = 1'b0;
        chk("refill_count", 32'(count), 32'd16);
        chk("refill_valid_vec", 32'(valid_vec), 32'hFFFF);
        chk("refill_in_ready", 32'(in_ready), 32'd0);
        chk("refill_issue_index", 32'(issue_index), 32'd1);
        for (int k = 0; k < 16; k++) begin
            drain_one((k < 15) ? k + 1 : 0, $sformatf("fill_drain%0d", k));
        end
        chk("fill_empty_count", 32'(count), 32'd0);

        // insert dependent on a slot completing in the same cycle
        insert(mk(3, 1, 0));
        issue_one(0, "same_iss0");
        in_valid  = 1'b1;
        in_instr  = mk(5, 3, 0);
        cmp_valid = 1'b1;
        cmp_index = 4'd0;
        tick();
        in_valid  = 1'b0;
        cmp_valid = 1'b0;
        chk("same_valid_vec", 32'(valid_vec), 32'h4000);
        chk("same_ready_vec", 32'(ready_vec), 32'h4000);
        chk("same_count", 32'(count), 32'd1);
        drain_one(1, "same_drain1");

        // age order differs from index order after slot reuse
        insert(mk(7, 1, 2));
        insert(mk(9, 7, 0));
        insert(mk(8, 1, 2));
        chk("age_ready0", 32'(ready_vec), 32'hA000);
        issue_one(0, "age_iss0");
        issue_one(2, "age_iss2");
        complete(2);
        insert(mk(10, 0, 0));
        chk("age_valid1", 32'(valid_vec), 32'hE000);
        chk("age_ready1", 32'(ready_vec), 32'h2000);
        complete(0);
        chk("age_ready2", 32'(ready_vec), 32'h6000);
        chk("age_index2", 32'(issue_index), 32'd1);
        insert(mk(11, 0, 0));
        chk("age_ready3", 32'(ready_vec), 32'hE000);
        drain_one(1, "age_drain_a");
        drain_one(2, "age_drain_b");
        drain_one(0, "age_drain_c");
        chk("age_empty_count", 32'(count), 32'd0);

        // WAW: tracked only when the optional hazard check is built in
        insert(mk(3, 1, 0));
        insert(mk(3, 2, 0));
`ifdef ESM_WAR_WAW_EN
        chk("waw_ready_vec", 32'(ready_vec), 32'h8000);
`else
        chk("waw_ready_vec", 32'(ready_vec), 32'hC000);
`endif
        drain_one(0, "waw_drain0");
        drain_one(1, "waw_drain1");
        chk("final_count", 32'(count), 32'd0);
        chk("final_in_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/esm_dep_tracker.md
# esm_dep_tracker

Parametrised dependency-tracking issue buffer for the ESM core, successor to the single-insert IRT/IDT pair. Accepts decoded instructions through a valid/ready handshake, records RAW (and optionally WAR/WAW) dependencies against all live entries in a BS×BS matrix, and issues the oldest dependency-free entry through a second handshake. Completion writeback clears the entry and its matrix column, releasing dependents.

## Interface
- IW, 32: instruction word width; rd=[11:7], rs1=[19:15], rs2=[24:20]
- BS, 16: buffer depth (power of two, ≥2); BSB=$clog2(BS)
- REGNUM, 32: architectural registers; RB=$clog2(REGNUM)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  insert request
- in_ready  out  1  free slot available
- in_instr  in  IW  instruction word
- in_regwrite  in  1  instruction writes rd (else rd treated as x0)
- in_alusrc  in  1  immediate operand (rs2 treated as x0)
- issue_valid  out  1  a ready entry is offered
- issue_ready  in  1  consumer accepts offered entry
- issue_index  out  BSB  slot of offered entry
- issue_instr  out  IW  stored word of offered entry
- cmp_valid  in  1  completion strobe
- cmp_index  in  BSB  slot completing
- valid_vec  out  BS  slot occupied (WAIT or ISSUED)
- ready_vec  out  BS  slot in WAIT with all-zero dependency row
- count  out  BSB+1  occupied slots

## Operation
- Per-slot state: FREE, WAIT, ISSUED; stored rd, rs1, rs2, instr word; dependency row dep[i][0:BS-1]; age matrix older[i][j].
- Insert (in_valid&&in_ready): allocate lowest-index FREE slot i (from registered state); state→WAIT; dep[i][j]=1 for each occupied j where rd_j≠0 and (rd_j==rs1 or rd_j==rs2). older[i][j]=1 for every occupied j.
- x0 never creates a dependency, in either direction.
- Issue select: oldest entry in ready_vec (entry with no set older bit among ready entries); issue_valid=|ready_vec. On issue_valid&&issue_ready: state→ISSUED.
- Completion (cmp_valid, slot in ISSUED): state→FREE, column cmp_index cleared in every row, row and age bits of slot cleared. Completion of a FREE or WAIT slot is ignored.
- Simultaneous insert + completion of j: new row's bit j forced 0 (completion wins). Freed slot not allocatable until next cycle.
- Simultaneous issue + completion of different slots: both take effect. Issue and insert same cycle: inserted entry not offered until next cycle.
- in_ready=(count<BS) from registered state; count updates +insert −completion each cycle.

## Timing
- Reset: all slots FREE, dep/age 0; in_ready=1, issue_valid=0, issue_index=0, issue_instr=0, valid_vec=0, ready_vec=0, count=0.
- Insert at edge t: slot visible in valid_vec after t; if independent, ready_vec/issue_valid high in the same cycle (combinational from registered state); min insert→issue-offer latency 1 cycle.
- Completion at edge t: dependents appear in ready_vec after t (1 cycle wake-up).
- issue_valid must stay asserted and issue_index stable until accepted unless an older entry becomes ready.
- Reset mid-operation discards all entries immediately (asynchronous).

## Configuration
- ESM_WAR_WAW_EN defined: insert also sets dep[i][j] when rd_i≠0 and (rd_i==rd_j or rd_i==rs1_j or rd_i==rs2_j) for occupied j.
- Undefined: RAW-only tracking; WAR/WAW ignored (downstream renaming assumed).

## Structure
- esm_pkg: slot-state enum (FREE/WAIT/ISSUED), field bit-position constants for rd/rs1/rs2, x0 constant.
- One sub-module: esm_age_select (BS-wide age matrix and oldest-ready one-hot/index encoder).

## Test plan
- Reset, insert add x3,x1,x2 -> slot 0, ready_vec=0x8000 (bit 0), issue_valid=1, issue_index=0 next cycle.
- Insert x3←…, then x5←x3+x4 -> slot1 dep[1][0]=1, not ready; issue+complete slot 0 -> slot 1 ready one cycle after completion.
- Fill 16 independent entries -> in_ready=0, count=16; complete one -> in_ready=1 next cycle, refill lowest free slot.
- Insert dependent on slot j in same cycle cmp_index=j -> new entry ready immediately after edge.
- Three ready entries inserted out of index order (reused slots) -> issue order follows insertion age, not index.
- With ESM_WAR_WAW_EN: x3←x1 then x3←x2 -> second waits on first; without macro -> both ready.
